// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared types and constants for the ID-stage hazard scoreboard.
//   A tag is {file, index}. File 0 is the scalar x file and file 1 is the
//   vector v file. The all-ones countdown value marks a variable-latency
//   producer that waits for an explicit writeback.
package hazard_pkg;

   localparam int DEF_NUM_REGS = 32;
   localparam int DEF_LAT_W    = 4;
   localparam int DEF_STAT_W   = 32;
   localparam int TAG_W        = $clog2(DEF_NUM_REGS) + 1;

   typedef logic [TAG_W-1:0]     tag_t;
   typedef logic [DEF_LAT_W-1:0] lat_t;

   localparam logic FILE_X = 1'b0;
   localparam logic FILE_V = 1'b1;

   localparam lat_t LAT_MAX = '1;

   // x0 is hardwired zero: it is never reserved and never stalls.
   function automatic logic is_x0(input tag_t tag);
      return tag == {FILE_X, {(TAG_W-1){1'b0}}};
   endfunction

endpackage

// File: rtl/scoreboard_entry.sv
// scoreboard_entry
//   One countdown reservation for a single register tag.
//   Ports:
//     clk, rst_n   clock, synchronous active-low reset
//     set_i        new reservation issued to this tag this cycle
//     set_val_i    countdown value to load (all-ones = variable latency)
//     clr_i        writeback releasing this tag
//     busy_o       reservation outstanding (cnt != 0)
//     cnt_o        current countdown value
//   Update priority: reset, set, clear, hold at all-ones, decrement.
module scoreboard_entry
   import hazard_pkg::*;
#(
   parameter int LAT_W = DEF_LAT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             set_i,
   input  logic [LAT_W-1:0] set_val_i,
   input  logic             clr_i,
   output logic             busy_o,
   output logic [LAT_W-1:0] cnt_o
);

   localparam logic [LAT_W-1:0] CNT_VARLAT = '1;

   logic [LAT_W-1:0] cnt_q;
   logic [LAT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (set_i) begin
         // An issue beats a same-cycle writeback to the same tag: the
         // writeback belongs to the older producer.
         cnt_d = set_val_i;
      end else if (clr_i) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_VARLAT) begin
         cnt_d = cnt_q;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign busy_o = (cnt_q != '0);
   assign cnt_o  = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Per-register countdown scoreboard for the x and v register files. It
//   stalls ID on RAW hazards and on WAW hazards that would let a younger
//   write complete before an older one.
//   Ports:
//     clk, rst_n                  clock, synchronous active-low reset
//     id_valid                    valid instruction in ID
//     id_rs{1,2,3}_en / id_rs*    source operand enables and tags
//     id_rd_en / id_rd            destination enable and tag
//     id_lat                      cycles until dependents may issue
//     id_varlat                   producer latency unknown, wait for wb
//     id_kill                     ID instruction squashed this cycle
//     wb_valid / wb_tag           variable-latency writeback release
//     pcwrite, ifid_write         front-end enables (low while stalled)
//     hazard                      bubble into ID/EX
//     stall_cycles                saturating count of stalled cycles
//   The tag width follows hazard_pkg, so NUM_REGS must match
//   DEF_NUM_REGS there.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int LAT_W    = DEF_LAT_W,
   parameter int STAT_W   = DEF_STAT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic              id_rs1_en,
   input  logic              id_rs2_en,
   input  logic              id_rs3_en,
   input  tag_t              id_rs1,
   input  tag_t              id_rs2,
   input  tag_t              id_rs3,
   input  logic              id_rd_en,
   input  tag_t              id_rd,
   input  logic [LAT_W-1:0]  id_lat,
   input  logic              id_varlat,
   input  logic              id_kill,
   input  logic              wb_valid,
   input  tag_t              wb_tag,
   output logic              pcwrite,
   output logic              ifid_write,
   output logic              hazard,
   output logic [STAT_W-1:0] stall_cycles
);

   localparam int               NUM_TAGS   = 2 * NUM_REGS;
   localparam logic [LAT_W-1:0] CNT_VARLAT = '1;

   logic [NUM_TAGS-1:0] busy;
   logic [LAT_W-1:0]    cnt [NUM_TAGS];

   logic             issue;
   logic             rd_write;
   logic [LAT_W-1:0] set_val;

   // Reservations only come from instructions that actually leave ID.
   assign rd_write = issue && id_rd_en && !is_x0(id_rd);
   assign set_val  = id_varlat ? CNT_VARLAT : id_lat;

   for (genvar t = 0; t < NUM_TAGS; t++) begin : g_entry
      logic set_t;
      if (t == 0) begin : g_x0
         assign set_t = 1'b0;
      end else begin : g_reg
         assign set_t = rd_write && (id_rd == tag_t'(t));
      end

      scoreboard_entry #(
         .LAT_W (LAT_W)
      ) u_entry (
         .clk       (clk),
         .rst_n     (rst_n),
         .set_i     (set_t),
         .set_val_i (set_val),
         .clr_i     (wb_valid && (wb_tag == tag_t'(t))),
         .busy_o    (busy[t]),
         .cnt_o     (cnt[t])
      );
   end

   // Source and destination muxes.
   logic             rs1_busy;
   logic             rs2_busy;
   logic             rs3_busy;
   logic [LAT_W-1:0] rd_cnt;

   assign rs1_busy = id_rs1_en && busy[id_rs1];
   assign rs2_busy = id_rs2_en && busy[id_rs2];
   assign rs3_busy = id_rs3_en && busy[id_rs3];
   assign rd_cnt   = cnt[id_rd];

   logic raw;
   logic waw;
   logic stall;

   assign raw = id_valid && (rs1_busy || rs2_busy || rs3_busy);

   // A new write may overtake the pending one only if it is guaranteed to
   // land no earlier; a variable-latency pending write blocks everything.
   assign waw = id_valid && id_rd_en && !is_x0(id_rd) && (rd_cnt != '0) &&
                ((rd_cnt == CNT_VARLAT) || (!id_varlat && (rd_cnt > id_lat)));

   assign stall = (raw || waw) && !id_kill;
   assign issue = id_valid && !stall && !id_kill;

   assign hazard     = stall;
   assign pcwrite    = !stall;
   assign ifid_write = !stall;

   // Stall statistics, saturating at all-ones.
   logic [STAT_W-1:0] stat_q;
   logic [STAT_W-1:0] stat_d;

   always_comb begin
      stat_d = stat_q;
      if (stall && (stat_q != '1)) begin
         stat_d = stat_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_q <= '0;
      end else begin
         stat_q <= stat_d;
      end
   end

   assign stall_cycles = stat_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        id_valid, id_rs1_en, id_rs2_en, id_rs3_en;
  tag_t        id_rs1, id_rs2, id_rs3, id_rd, wb_tag;
  logic        id_rd_en, id_varlat, id_kill, wb_valid;
  logic [3:0]  id_lat;
  logic        pcwrite, ifid_write, hazard;
  logic [31:0] stall_cycles;

  hazard_scoreboard dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs1_en    (id_rs1_en),
    .id_rs2_en    (id_rs2_en),
    .id_rs3_en    (id_rs3_en),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs3       (id_rs3),
    .id_rd_en     (id_rd_en),
    .id_rd        (id_rd),
    .id_lat       (id_lat),
    .id_varlat    (id_varlat),
    .id_kill      (id_kill),
    .wb_valid     (wb_valid),
    .wb_tag       (wb_tag),
    .pcwrite      (pcwrite),
    .ifid_write   (ifid_write),
    .hazard       (hazard),
    .stall_cycles (stall_cycles)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // 1 unit after that, well away from either clock edge.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  function automatic tag_t xt(input int i);
    return {FILE_X, i[4:0]};
  endfunction

  function automatic tag_t vt(input int i);
    return {FILE_V, i[4:0]};
  endfunction

  task automatic idle();
    id_valid = 0; id_rs1_en = 0; id_rs2_en = 0; id_rs3_en = 0;
    id_rs1 = '0; id_rs2 = '0; id_rs3 = '0;
    id_rd_en = 0; id_rd = '0; id_lat = '0; id_varlat = 0; id_kill = 0;
    wb_valid = 0; wb_tag = '0;
  endtask

  task automatic wr(input tag_t rd, input logic [3:0] lat, input logic varlat);
    idle();
    id_valid = 1; id_rd_en = 1; id_rd = rd; id_lat = lat; id_varlat = varlat;
  endtask

  task automatic rd1(input tag_t rs);
    idle();
    id_valid = 1; id_rs1_en = 1; id_rs1 = rs;
  endtask

  task automatic check_stall(input string tag, input logic exp);
    check({tag, "_hazard"}, {31'd0, hazard}, {31'd0, exp});
    check({tag, "_pcwrite"}, {31'd0, pcwrite}, {31'd0, ~exp});
    check({tag, "_ifid"}, {31'd0, ifid_write}, {31'd0, ~exp});
  endtask

  initial begin
    // reset
    idle();
    rst_n = 0;
    next(); next();
    #1;
    check_stall("reset", 1'b0);
    check("reset_stat", stall_cycles, 32'd0);
    rst_n = 1;
    next();
    #1;
    check_stall("post_reset", 1'b0);

    // load-use: x5 lat 1, dependent stalls exactly one cycle
    wr(xt(5), 4'd1, 0);
    #1 check_stall("lu_issue", 1'b0);
    next();
    rd1(xt(5));
    #1 check_stall("lu_dep", 1'b1);
    next();
    #1 check_stall("lu_dep_go", 1'b0);
    next();
    idle();
    #1 check("lu_stat", stall_cycles, 32'd1);

    // multi-cycle: MUL x7 lat 3 -> 3 stall cycles
    wr(xt(7), 4'd3, 0);
    next();
    rd1(xt(7));
    for (int i = 0; i < 3; i++) begin
      #1 check_stall("mul_dep", 1'b1);
      next();
    end
    #1 check_stall("mul_dep_go", 1'b0);
    next();
    idle();
    #1 check("mul_stat", stall_cycles, 32'd4);

    // variable latency: vector load v3, consumer waits for wb
    wr(vt(3), 4'd0, 1);
    next();
    rd1(vt(3));
    for (int i = 0; i < 8; i++) begin
      #1 check("var_wait", {31'd0, hazard}, 32'd1);
      next();
    end
    wb_valid = 1; wb_tag = vt(3);
    #1 check("var_wb_cycle", {31'd0, hazard}, 32'd1);
    next();
    wb_valid = 0;
    #1 check_stall("var_after_wb", 1'b0);
    next();
    idle();
    #1 check("var_stat", stall_cycles, 32'd13);

    // WAW against a variable-latency write to x9
    wr(xt(9), 4'd0, 1);
    next();
    wr(xt(9), 4'd0, 0);
    for (int i = 0; i < 2; i++) begin
      #1 check("waw_var", {31'd0, hazard}, 32'd1);
      next();
    end
    wb_valid = 1; wb_tag = xt(9);
    #1 check("waw_wb_cycle", {31'd0, hazard}, 32'd1);
    next();
    wb_valid = 0;
    #1 check_stall("waw_after_wb", 1'b0);
    next();
    // x9 at cnt 2, new write lat 3 lands later -> allowed
    wr(xt(9), 4'd2, 0);
    #1 check("waw_set2", {31'd0, hazard}, 32'd0);
    next();
    wr(xt(9), 4'd3, 0);
    #1 check("waw_lat3_ok", {31'd0, hazard}, 32'd0);
    next();
    // x9 at cnt 3, write lat 1 would complete first -> stall
    wr(xt(9), 4'd1, 0);
    #1 check("waw_lat1_stall", {31'd0, hazard}, 32'd1);
    next();
    idle();
    next(); next(); next();
    #1 check("waw_stat", stall_cycles, 32'd17);

    // file separation and x0
    wr(vt(1), 4'd0, 1);
    next();
    idle(); id_valid = 1; id_rs2_en = 1; id_rs2 = xt(1);
    #1 check("x1_vs_v1", {31'd0, hazard}, 32'd0);
    next();
    idle(); id_valid = 1; id_rs3_en = 1; id_rs3 = vt(1);
    #1 check("v1_rs3", {31'd0, hazard}, 32'd1);
    next();
    idle(); wb_valid = 1; wb_tag = vt(1);
    next();
    wr(xt(0), 4'd5, 0);
    #1 check("x0_write", {31'd0, hazard}, 32'd0);
    next();
    rd1(xt(0));
    wb_valid = 1; wb_tag = xt(0);
    #1 check("x0_read", {31'd0, hazard}, 32'd0);
    next();

    // issue and wb to the same tag in one cycle: issue wins
    wr(xt(12), 4'd2, 0);
    wb_valid = 1; wb_tag = xt(12);
    next();
    rd1(xt(12));
    for (int i = 0; i < 2; i++) begin
      #1 check("iss_wb_dep", {31'd0, hazard}, 32'd1);
      next();
    end
    #1 check("iss_wb_go", {31'd0, hazard}, 32'd0);
    next();
    idle();
    #1 check("iss_wb_stat", stall_cycles, 32'd20);

    // reset during a reservation on x4
    wr(xt(4), 4'd3, 0);
    next();
    idle();
    rst_n = 0;
    next();
    #1 check("midrst_stat", stall_cycles, 32'd0);
    rst_n = 1;
    rd1(xt(4));
    #1 check_stall("midrst_dep", 1'b0);
    next();

    // kill during a would-be RAW stall: no stall, no reservation, no count
    wr(xt(6), 4'd3, 0);
    next();
    idle();
    id_valid = 1; id_rs1_en = 1; id_rs1 = xt(6);
    id_rd_en = 1; id_rd = xt(8); id_lat = 4'd4; id_kill = 1;
    #1 check_stall("kill", 1'b0);
    next();
    rd1(xt(8));
    #1 check("kill_no_resv", {31'd0, hazard}, 32'd0);
    next();
    idle();
    #1 check("kill_stat", stall_cycles, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Scoreboard-based hazard unit for the RV64IV pipeline. It replaces single-cycle load-use detection with per-register countdown reservations covering the scalar (x) and vector (v) register files. It stalls the ID stage for RAW and WAW hazards against multi-cycle and variable-latency producers, and keeps a saturating stall-cycle counter. It sits beside the ID stage and drives PC, IF/ID write-enable and the ID/EX bubble.

## Interface
Parameters:
- NUM_REGS, 32, registers per file (power of two)
- LAT_W, 4, countdown width; LAT_MAX = 2**LAT_W-1 is reserved as the "variable latency" marker
- STAT_W, 32, stall counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset; state clears on the rising clk edge while low
- id_valid  in  1  valid instruction in ID
- id_rs1_en, id_rs2_en, id_rs3_en  in  1 each  source operand used
- id_rs1, id_rs2, id_rs3  in  TAG_W each  source tag = {file, index}; file 0 = x, 1 = v; TAG_W = clog2(NUM_REGS)+1
- id_rd_en  in  1  instruction writes a register
- id_rd  in  TAG_W  destination tag
- id_lat  in  LAT_W  cycles after issue before a dependent may issue; 0 = fully forwarded
- id_varlat  in  1  producer latency unknown (cache miss path, vector mem, divide)
- id_kill  in  1  ID instruction squashed this cycle (branch flush); no reservation
- wb_valid  in  1  variable-latency result written back
- wb_tag  in  TAG_W  tag released by the writeback
- pcwrite  out  1  PC update enable
- ifid_write  out  1  IF/ID register write enable
- hazard  out  1  insert bubble into ID/EX
- stall_cycles  out  STAT_W  saturating count of stalled cycles

## Operation
- State: one counter cnt[t] per tag (2*NUM_REGS entries). Tag t is busy when cnt[t] != 0.
- x0 (tag 0) is never reserved and never stalls. Its reads and writes are ignored. v0 is an ordinary tag.
- RAW stall: id_valid and, for any enabled source s, cnt[s] != 0.
- WAW stall: id_valid and id_rd_en and cnt[id_rd] != 0 and either (cnt[id_rd] == LAT_MAX) or (!id_varlat and cnt[id_rd] > id_lat). This prevents out-of-order completion to the same register.
- stall = (RAW or WAW) and !id_kill. Outputs: hazard = stall; pcwrite = ifid_write = !stall.
- Issue = id_valid and !stall and !id_kill.
- Per-cycle counter update, highest priority first:
  1. Reset: all cnt = 0.
  2. Issue with id_rd_en to tag id_rd (not x0): cnt = LAT_MAX if id_varlat, else id_lat.
  3. wb_valid to wb_tag: cnt = 0.
  4. cnt == LAT_MAX: hold.
  5. cnt != 0: decrement.
- A non-variable id_lat equal to LAT_MAX is illegal. The producing stage saturates it to LAT_MAX-1.
- stall_cycles increments on every cycle with stall = 1 and saturates at all-ones. It resets to 0.

## Timing
- Outputs are combinational from the ID inputs and the registered counters. Scoreboard latency is one cycle: an issue at edge T is visible from cycle T+1.
- A load with id_lat = 1 issued in cycle T: a dependent in T+1 stalls one cycle and issues in T+2. This matches the legacy load-use bubble.
- id_lat = 0: no stall in any cycle.
- During and immediately after reset: all cnt = 0, pcwrite = 1, ifid_write = 1, hazard = 0, stall_cycles = 0.
- Reset asserted mid-reservation: all reservations are dropped on that edge with no residual stall.
- Issue and wb_valid to the same tag in the same cycle: the issue wins and the new reservation stands.
- wb_valid to a non-busy tag or to x0: no effect.
- id_kill during a would-be stall: no stall and no reservation. The counter is still not incremented for that cycle.
- A stall held for many cycles keeps IF/ID and PC frozen. Counters keep decrementing normally.

## Structure
- Shared package hazard_pkg:
  - tag_t typedef
  - FILE_X / FILE_V constants
  - LAT_MAX
  - the helper is_x0(tag)
- Sub-module scoreboard_entry, one per tag. It holds the counter, applies the update-priority rule, and outputs busy and cnt.
- The top level contains:
  - the generate array of entries
  - three source muxes and the destination mux
  - the stall logic
  - the statistics counter

## Test plan
- Load-use: issue x5 with lat 1, then ADD reading x5 in the next cycle -> hazard = 1 for exactly 1 cycle, issue in cycle +2, stall_cycles = 1.
- Multi-cycle: MUL writing x7 with lat 3, immediately followed by a reader of x7 -> 3 stall cycles, then pcwrite = 1.
- Variable latency: vector load to v3 with varlat; a consumer of v3 stalls indefinitely; wb_valid with tag {1,3} at cycle 10 -> consumer issues in cycle 11.
- WAW: varlat write to x9 pending, then an ALU op writing x9 with lat 0 -> stall until wb. With x9 at cnt 2, a write with lat 3 -> no stall.
- x0/file separation: a reservation on v1 does not stall a reader of x1. A write to x0 with lat 5 followed by a reader of x0 -> no stall.
- Reset and kill:
  - rst_n low while cnt[x4] = 3 -> a reader of x4 issues right after reset with stall_cycles = 0.
  - id_kill with a pending RAW -> hazard = 0 and no reservation created.
